lsu_rmw: RTL and testbench
==========================

Name: lsu_rmw

Overview:
- Load/store unit between the datapath's ALU/register-file outputs and the 64-bit doubleword data memory.
- Takes byte-addressed RV64 load/store requests (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD) and converts them to doubleword-indexed memory accesses.
- Sub-doubleword stores use a read-modify-write sequence; load results are sign- or zero-extended.
- Misaligned, out-of-range or illegal requests are reported and never touch memory.

Parameters:
- MEM_DEPTH_LOG2, 8, log2 of memory depth in doublewords; 8 gives 256 entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 encoding of access size and signedness.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_error  out  1  valid only with resp_valid; set for misaligned, out-of-range or illegal requests.
- mem_address  out  64  doubleword index, zero-extended.
- mem_write_data  out  64  merged doubleword to write.
- mem_write  out  1  write strobe; memory writes on the clk edge.
- mem_read  out  1  read enable.
- mem_read_data  in  64  memory data; combinational from mem_read and mem_address.

Behaviour:
- Reset (asynchronous, active-high):
  - Immediately: state=IDLE; resp_valid, resp_error, resp_rdata, mem_read, mem_write = 0; mem_address, mem_write_data = 0; all captured request registers = 0.
  - req_ready=1 while reset is asserted, but no request is accepted until reset deasserts.
- Accept: in IDLE, req_valid & req_ready at a rising edge registers req_write, req_funct3, req_addr, req_wdata. Request inputs are ignored in every other state.
- Size from funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double. funct3[2]=1 means zero-extend (loads only).
- Illegal requests:
  - load with funct3=111;
  - store with funct3[2]=1;
  - address not aligned to its size (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0);
  - any req_addr bit above 3+MEM_DEPTH_LOG2-1 set.
- Lane offset = addr[2:0]. mem_address = {zeros, addr[MEM_DEPTH_LOG2+2:3]}.
- Memory-interface outputs are decoded from state and the captured registers. mem_address and mem_write_data are 0 outside READ/WRITE.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> RESP: accepted request is illegal. No memory access occurs.
  - IDLE -> WRITE: legal SD.
  - IDLE -> READ: every other legal request.
  - READ: mem_read=1. mem_read_data is captured at the end of the cycle. Load -> RESP; store -> WRITE.
  - WRITE: mem_write=1. mem_write_data = old doubleword with the selected byte lanes replaced by req_wdata's low bytes shifted to the lane offset. For SD, mem_write_data = req_wdata. Next state RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready returns to 1 in the following cycle.
- Latency from the acceptance edge to resp_valid:
  - legal load: 2 cycles;
  - SB/SH/SW: 3 cycles;
  - SD: 2 cycles;
  - illegal request: 1 cycle.
- Load extension: the selected lanes are shifted down. With funct3[2]=0 they are sign-extended from bit 7/15/31; with funct3[2]=1 they are zero-extended. LD returns the raw doubleword.
- resp_rdata and resp_error are registered. They are held from RESP until the next RESP and are meaningful only while resp_valid=1.
- Reset mid-operation aborts the access:
  - asserted during READ: no write follows;
  - asserted during WRITE: mem_write drops asynchronously and the edge must not commit.
- No back-to-back acceptance: at most one outstanding request; the minimum request spacing is response latency + 1.

Test Plan:
- Memory preloaded with mem[i]=i. LD addr 0x18 -> resp_valid 2 cycles after acceptance, resp_rdata=0x3, resp_error=0, mem_read high exactly one cycle, mem_address=3.
- SD addr 0x8, data 0xFFFFFFFF80808081 -> mem_write for one cycle with mem_address=1, no READ cycle. Then LB 0x8 -> 0xFFFFFFFFFFFFFF81; LBU 0x9 -> 0x80; LH 0xA -> 0xFFFFFFFFFFFF8080; LWU 0xC -> 0x00000000FFFFFFFF.
- SB addr 0x13, data 0x12345678AB onto mem[2]=2 -> READ then WRITE with mem_write_data=0x00000000AB000002. A following LD 0x10 returns the same value; response arrives 3 cycles after acceptance.
- SH addr 0x1 / LW addr 0x6 / load funct3=111 / addr 0x800 (MEM_DEPTH_LOG2=8) -> resp_valid one cycle after acceptance, resp_error=1, resp_rdata=0, mem_read=mem_write=0 throughout.
- SW addr 0x4 accepted, then reset asserted during READ -> mem_write never asserts, mem[0] unchanged, outputs zero immediately, req_ready=1, a fresh LD 0x0 after release returns 0x0.
- req_valid held high continuously -> exactly one acceptance per response. req_ready is low from the cycle after acceptance until the cycle after resp_valid, and no request is lost or duplicated.

Source files
------------

// File: rtl/lsu_rmw.sv
// RV64 load/store unit for a 64-bit doubleword memory. Sub-doubleword stores
// are done as read-modify-write, and load data is sign- or zero-extended.
module lsu_rmw #(
  parameter int unsigned MEM_DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_read_data
);

  localparam int unsigned AW = MEM_DEPTH_LOG2 + 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   old_q, old_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          misalign;
  logic          illegal;
  logic [7:0]    lane_mask;
  logic [63:0]   wdata_sh;
  logic [63:0]   merged;

  function automatic logic [63:0] load_ext(input logic [63:0] dw,
                                           input logic [2:0]  f3,
                                           input logic [2:0]  off);
    logic [63:0] sh;
    logic [63:0] res;
    sh = dw >> {off, 3'b000};
    case (f3[1:0])
      2'd0:    res = f3[2] ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    res = f3[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    res = f3[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  always_comb begin
    case (req_funct3[1:0])
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = |req_addr[2:0];
    endcase
    illegal = misalign | (|req_addr[63:AW]) |
              (req_write ? req_funct3[2] : (req_funct3 == 3'b111));
  end

  // SD uses the same merge path with all eight lanes selected.
  always_comb begin
    case (f3_q[1:0])
      2'd0:    lane_mask = 8'h01 << addr_q[2:0];
      2'd1:    lane_mask = 8'h03 << addr_q[2:0];
      2'd2:    lane_mask = 8'h0F << addr_q[2:0];
      default: lane_mask = 8'hFF;
    endcase
    wdata_sh = wdata_q << {addr_q[2:0], 3'b000};
    merged   = old_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (lane_mask[i]) merged[i*8 +: 8] = wdata_sh[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          f3_d    = req_funct3;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          if (illegal) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (req_write && (req_funct3[1:0] == 2'd3)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        old_d = mem_read_data;
        if (wr_q) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
          rdata_d = load_ext(mem_read_data, f3_q, addr_q[2:0]);
          err_d   = 1'b0;
        end
      end
      WRITE: begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    resp_valid     = (state_q == RESP);
    mem_read       = (state_q == READ);
    mem_write      = (state_q == WRITE);
    mem_address    = (mem_read || mem_write) ?
                     {{(64-MEM_DEPTH_LOG2){1'b0}}, addr_q[AW-1:3]} : '0;
    mem_write_data = mem_write ? merged : '0;
    resp_rdata     = rdata_q;
    resp_error     = err_q;
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: vector table through a response scoreboard, plus
// hand-driven reset-abort and continuous-request sequences.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_read_data;

  lsu_rmw #(.MEM_DEPTH_LOG2(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  initial forever #5 clk = ~clk;

  logic [63:0] mem [256];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'(i);
      mem_init <= 1'b1;
    end else if (mem_write && mem_address < 64'd256) begin
      mem[mem_address[7:0]] <= mem_write_data;
    end
  end

  always_comb begin
    mem_read_data = '0;
    if (mem_read && mem_address < 64'd256) mem_read_data = mem[mem_address[7:0]];
  end

  typedef struct {
    string       name;
    logic        w;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] rd;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [63:0] maddr;
    logic [63:0] mwd;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
    int   rd0;
    int   wr0;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic sb_on = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic w, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] d,
                              input logic [63:0] rd, input logic err, input int lat,
                              input int nrd, input int nwr, input logic [63:0] maddr,
                              input logic [63:0] mwd);
    vec_t v;
    v.name = nm; v.w = w; v.f3 = f3; v.a = a; v.d = d; v.rd = rd; v.err = err;
    v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.maddr = maddr; v.mwd = mwd;
    return v;
  endfunction

  // Scoreboard: checks the memory interface against the outstanding request
  // and pops/compares the expected response when resp_valid appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (sb_on && sbq.size() != 0) begin
        if (mem_read || mem_write) chk({sbq[0].v.name, "/maddr"}, mem_address, sbq[0].v.maddr);
        if (mem_write) chk({sbq[0].v.name, "/mwdata"}, mem_write_data, sbq[0].v.mwd);
      end
      if (sb_on && resp_valid) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 want 0");
        end else begin
          e = sbq.pop_front();
          chk({e.v.name, "/rdata"}, resp_rdata, e.v.rd);
          chk({e.v.name, "/error"}, 64'(resp_error), 64'(e.v.err));
          chk({e.v.name, "/latency"}, 64'(cyc - e.acc), 64'(e.v.lat));
          chk({e.v.name, "/nread"}, 64'(rd_cnt - e.rd0), 64'(e.v.nrd));
          chk({e.v.name, "/nwrite"}, 64'(wr_cnt - e.wr0), 64'(e.v.nwr));
        end
      end
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL %s/ready_timeout: got req_ready=0 want 1", nm);
    end
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    int   n = 0;
    wait_ready(v.name);
    e.v = v; e.acc = cyc; e.rd0 = rd_cnt; e.wr0 = wr_cnt;
    sbq.push_back(e);
    req_valid = 1'b1; req_write = v.w; req_funct3 = v.f3;
    req_addr = v.a; req_wdata = v.d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL %s/resp_timeout: got no resp_valid want resp_valid=1", v.name);
      sbq.delete();
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] d);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
  endtask

  initial begin
    int acc_n, resp_n, rd0, wr0;

    vecs.push_back(mk("ld18",   0, 3'b011, 64'h18, 0, 64'h3, 0, 2, 1, 0, 3, 0));
    vecs.push_back(mk("sd8",    1, 3'b011, 64'h8, 64'hFFFFFFFF80808081, 0, 0, 2, 0, 1, 1, 64'hFFFFFFFF80808081));
    vecs.push_back(mk("lb8",    0, 3'b000, 64'h8, 0, 64'hFFFFFFFFFFFFFF81, 0, 2, 1, 0, 1, 0));
    vecs.push_back(mk("lbu9",   0, 3'b100, 64'h9, 0, 64'h80, 0, 2, 1, 0, 1, 0));
    vecs.push_back(mk("lhA",    0, 3'b001, 64'hA, 0, 64'hFFFFFFFFFFFF8080, 0, 2, 1, 0, 1, 0));
    vecs.push_back(mk("lwuC",   0, 3'b110, 64'hC, 0, 64'h00000000FFFFFFFF, 0, 2, 1, 0, 1, 0));
    vecs.push_back(mk("sb13",   1, 3'b000, 64'h13, 64'h12345678AB, 0, 0, 3, 1, 1, 2, 64'h00000000AB000002));
    vecs.push_back(mk("ld10",   0, 3'b011, 64'h10, 0, 64'h00000000AB000002, 0, 2, 1, 0, 2, 0));
    vecs.push_back(mk("sh1_mis", 1, 3'b001, 64'h1, 64'hFFFF, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("lw6_mis", 0, 3'b010, 64'h6, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ld_f7",  0, 3'b111, 64'h20, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ld800",  0, 3'b011, 64'h800, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ld4_mis", 0, 3'b011, 64'h4, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("sw24",   1, 3'b010, 64'h24, 64'hDEADBEEF, 0, 0, 3, 1, 1, 4, 64'hDEADBEEF00000004));
    vecs.push_back(mk("lw24",   0, 3'b010, 64'h24, 0, 64'hFFFFFFFFDEADBEEF, 0, 2, 1, 0, 4, 0));
    vecs.push_back(mk("lhu26",  0, 3'b101, 64'h26, 0, 64'hDEAD, 0, 2, 1, 0, 4, 0));
    vecs.push_back(mk("sh2E",   1, 3'b001, 64'h2E, 64'hFFFF1234, 0, 0, 3, 1, 1, 5, 64'h1234000000000005));
    vecs.push_back(mk("ld28",   0, 3'b011, 64'h28, 0, 64'h1234000000000005, 0, 2, 1, 0, 5, 0));
    vecs.push_back(mk("lb2F",   0, 3'b000, 64'h2F, 0, 64'h12, 0, 2, 1, 0, 5, 0));
    vecs.push_back(mk("st_f4",  1, 3'b100, 64'h30, 64'h1, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ld7F8",  0, 3'b011, 64'h7F8, 0, 64'hFF, 0, 2, 1, 0, 255, 0));
    vecs.push_back(mk("lh7FE",  0, 3'b001, 64'h7FE, 0, 64'h0, 0, 2, 1, 0, 255, 0));
    vecs.push_back(mk("ld400",  0, 3'b011, 64'h400, 0, 64'h80, 0, 2, 1, 0, 128, 0));
    vecs.push_back(mk("lw_top", 0, 3'b010, 64'h8000000000000000, 0, 0, 1, 1, 0, 0, 0, 0));

    // Reset state, and no acceptance while reset is held.
    #1 reset = 1'b1;
    #2;
    chk("rst/req_ready", 64'(req_ready), 64'h1);
    chk("rst/resp_valid", 64'(resp_valid), 64'h0);
    chk("rst/resp_rdata", resp_rdata, 64'h0);
    chk("rst/resp_error", 64'(resp_error), 64'h0);
    chk("rst/mem_read", 64'(mem_read), 64'h0);
    chk("rst/mem_write", 64'(mem_write), 64'h0);
    chk("rst/mem_address", mem_address, 64'h0);
    chk("rst/mem_wdata", mem_write_data, 64'h0);
    drive(0, 3'b011, 64'h18, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/no_accept_read", 64'(mem_read), 64'h0);
    chk("rst/no_accept_ready", 64'(req_ready), 64'h1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    sb_on = 1'b1;
    foreach (vecs[i]) send(vecs[i]);
    sb_on = 1'b0;

    // Reset during READ of a sub-word store: no write may follow.
    wait_ready("abort_rd");
    wr0 = wr_cnt;
    drive(1, 3'b010, 64'h4, 64'h11111111);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_rd/in_read", 64'(mem_read), 64'h1);
    reset = 1'b1;
    #1;
    chk("abort_rd/mem_read", 64'(mem_read), 64'h0);
    chk("abort_rd/mem_write", 64'(mem_write), 64'h0);
    chk("abort_rd/mem_address", mem_address, 64'h0);
    chk("abort_rd/req_ready", 64'(req_ready), 64'h1);
    chk("abort_rd/resp_rdata", resp_rdata, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rd/nwrite", 64'(wr_cnt - wr0), 64'h0);
    chk("abort_rd/mem0", mem[0], 64'h0);

    // Reset during WRITE: strobe drops at once and the edge does not commit.
    wait_ready("abort_wr");
    drive(1, 3'b000, 64'h0, 64'h55);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_wr/in_write", 64'(mem_write), 64'h1);
    reset = 1'b1;
    #1;
    chk("abort_wr/mem_write", 64'(mem_write), 64'h0);
    chk("abort_wr/mem_wdata", mem_write_data, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_wr/mem0", mem[0], 64'h0);

    sb_on = 1'b1;
    send(mk("ld0_post", 0, 3'b011, 64'h0, 0, 64'h0, 0, 2, 1, 0, 0, 0));
    sb_on = 1'b0;

    // req_valid held high: one acceptance per response, none lost.
    wait_ready("stream");
    acc_n = 0; resp_n = 0; rd0 = rd_cnt;
    drive(0, 3'b011, 64'h18, 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc_n++;
      if (resp_valid) begin
        resp_n++;
        chk("stream/ready_in_resp", 64'(req_ready), 64'h0);
        chk("stream/rdata", resp_rdata, 64'h3);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("stream/ready_after_resp", 64'(req_ready), 64'h1);
    chk("stream/accepts", 64'(acc_n), 64'd10);
    chk("stream/responses", 64'(resp_n), 64'(acc_n));
    chk("stream/reads", 64'(rd_cnt - rd0), 64'(acc_n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "timeout");
  end

endmodule
